ad9958_reg_writer: RTL and testbench

//  Command sequencer directly upstream of the four-bit SPI shifter. Accepts AD9958 register-write requests,

---
 rtl/ad9958_reg_writer.sv | 218 +++++++++++++++++++++
 tb/tb_ad9958_reg_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9958_reg_writer.sv
// AD9958 register-write sequencer feeding the four-bit SPI shifter.
// Optional CSR channel-shadow prefix writes enabled by defining AD9958_CSR_SHADOW_EN.
module ad9958_reg_writer #(
  parameter int UPD_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_chan,
  input  logic        req_update,
  input  logic        four_bit_mode,
  output logic        spi_trigger,
  input  logic        spi_busy,
  output logic        spi_four_bit,
  output logic [5:0]  spi_bits_to_send,
  output logic [63:0] spi_data,
  output logic        io_update,
  output logic        done,
  output logic        err_bad_addr,
  output logic        err_timeout
);

  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int UPD_W = $clog2(UPD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TRIG,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state;
  logic [4:0]       addr_q;
  logic [31:0]      data_q;
  logic             update_q;
  logic             four_bit_q;
  logic [ACK_W-1:0] ack_cnt;
  logic [UPD_W-1:0] upd_cnt;

`ifdef AD9958_CSR_SHADOW_EN
  logic [3:0] chan_q;
  logic [3:0] shadow;
  logic       shadow_valid;
  logic       csr_phase;
`else
  logic unused_chan;
  assign unused_chan = ^req_chan;
`endif

  function automatic logic [2:0] nbytes(input logic [4:0] a);
    case (a)
      5'h00:                      nbytes = 3'd1;
      5'h01, 5'h03, 5'h06:        nbytes = 3'd3;
      5'h02, 5'h05, 5'h07:        nbytes = 3'd2;
      default:                    nbytes = 3'd4;
    endcase
  endfunction

  // Instruction byte (write, address) followed by the register's significant data bytes.
  function automatic logic [63:0] build_word(input logic [4:0] a, input logic [31:0] d);
    logic [7:0] instr;
    instr = {3'b000, a};
    case (nbytes(a))
      3'd1:    build_word = {48'b0, instr, d[7:0]};
      3'd2:    build_word = {40'b0, instr, d[15:0]};
      3'd3:    build_word = {32'b0, instr, d[23:0]};
      default: build_word = {24'b0, instr, d};
    endcase
  endfunction

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      addr_q           <= '0;
      data_q           <= '0;
      update_q         <= 1'b0;
      four_bit_q       <= 1'b0;
      ack_cnt          <= '0;
      upd_cnt          <= '0;
      spi_trigger      <= 1'b0;
      spi_four_bit     <= 1'b0;
      spi_bits_to_send <= '0;
      spi_data         <= '0;
      io_update        <= 1'b0;
      done             <= 1'b0;
      err_bad_addr     <= 1'b0;
      err_timeout      <= 1'b0;
`ifdef AD9958_CSR_SHADOW_EN
      chan_q           <= '0;
      shadow           <= '0;
      shadow_valid     <= 1'b0;
      csr_phase        <= 1'b0;
`endif
    end else begin
      spi_trigger  <= 1'b0;
      done         <= 1'b0;
      err_bad_addr <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            data_q     <= req_data;
            update_q   <= req_update;
            four_bit_q <= four_bit_mode;
            if (req_addr > 5'h18) begin
              err_bad_addr <= 1'b1;
            end else begin
              state <= S_LOAD;
`ifdef AD9958_CSR_SHADOW_EN
              chan_q    <= req_chan;
              csr_phase <= (req_addr >= 5'h03) && (!shadow_valid || (req_chan != shadow));
`endif
            end
          end
        end
        S_LOAD: begin
          spi_four_bit <= four_bit_q;
          state        <= S_TRIG;
`ifdef AD9958_CSR_SHADOW_EN
          if (csr_phase) begin
            spi_data         <= {48'b0, 8'h00, chan_q, 1'b0, four_bit_q, four_bit_q, 1'b0};
            spi_bits_to_send <= 6'd16;
          end else begin
            spi_data         <= build_word(addr_q, data_q);
            spi_bits_to_send <= {nbytes(addr_q) + 3'd1, 3'b000};
          end
`else
          spi_data         <= build_word(addr_q, data_q);
          spi_bits_to_send <= {nbytes(addr_q) + 3'd1, 3'b000};
`endif
        end
        // A still-busy shifter is a previous transfer finishing; wait without timing out.
        S_TRIG: begin
          if (!spi_busy) begin
            spi_trigger <= 1'b1;
            ack_cnt     <= '0;
            state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (spi_busy) begin
            state <= S_WAIT_DONE;
          end else if (ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
`ifdef AD9958_CSR_SHADOW_EN
            shadow_valid <= 1'b0;
            csr_phase    <= 1'b0;
`endif
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!spi_busy) begin
`ifdef AD9958_CSR_SHADOW_EN
            if (csr_phase) begin
              shadow       <= chan_q;
              shadow_valid <= 1'b1;
              csr_phase    <= 1'b0;
              state        <= S_LOAD;
            end else begin
              if (addr_q == 5'h00) begin
                shadow       <= data_q[7:4];
                shadow_valid <= 1'b1;
              end
              if (update_q) begin
                io_update <= 1'b1;
                upd_cnt   <= '0;
                state     <= S_UPDATE;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
`else
            if (update_q) begin
              io_update <= 1'b1;
              upd_cnt   <= '0;
              state     <= S_UPDATE;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
`endif
          end
        end
        S_UPDATE: begin
          if (upd_cnt == UPD_W'(UPD_CYCLES - 1)) begin
            io_update <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            upd_cnt <= upd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9958_reg_writer.sv
// Directed-vector bench for ad9958_reg_writer with a procedural model of the SPI shifter's busy flag.
module tb_ad9958_reg_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_chan = '0;
  logic        req_update = 1'b0;
  logic        four_bit_mode = 1'b0;
  logic        spi_trigger;
  logic        spi_busy = 1'b0;
  logic        spi_four_bit;
  logic [5:0]  spi_bits_to_send;
  logic [63:0] spi_data;
  logic        io_update;
  logic        done;
  logic        err_bad_addr;
  logic        err_timeout;

  always #5 clock = ~clock;

  ad9958_reg_writer dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_data         (req_data),
    .req_chan         (req_chan),
    .req_update       (req_update),
    .four_bit_mode    (four_bit_mode),
    .spi_trigger      (spi_trigger),
    .spi_busy         (spi_busy),
    .spi_four_bit     (spi_four_bit),
    .spi_bits_to_send (spi_bits_to_send),
    .spi_data         (spi_data),
    .io_update        (io_update),
    .done             (done),
    .err_bad_addr     (err_bad_addr),
    .err_timeout      (err_timeout)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        upd;
    logic        fb;
    logic        bad;
    logic [5:0]  exp_bits;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int trig_cnt, upd_cnt, done_cnt, bad_cnt, to_cnt;
  int trig_cyc, first_upd_cyc, done_cyc, bad_cyc, to_cyc, fall_cyc, accept_cyc;
  int busy_left = 0;
  bit no_busy = 1'b0;
  logic [63:0] snap_data, first_data;
  logic [5:0]  snap_bits, first_bits;
  logic        snap_fb;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One clock: sample 1 ns after the edge, log events, then advance the shifter model.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (spi_trigger) begin
      trig_cnt++;
      trig_cyc  = cyc;
      snap_data = spi_data;
      snap_bits = spi_bits_to_send;
      snap_fb   = spi_four_bit;
      if (trig_cnt == 1) begin
        first_data = spi_data;
        first_bits = spi_bits_to_send;
      end
    end
    if (io_update) begin
      if (upd_cnt == 0) first_upd_cyc = cyc;
      upd_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_bad_addr) begin
      bad_cnt++;
      bad_cyc = cyc;
    end
    if (err_timeout) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (!no_busy) begin
      if (spi_trigger) begin
        spi_busy  = 1'b1;
        busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          spi_busy = 1'b0;
          fall_cyc = cyc;
        end
      end
    end
  endtask

  task automatic clearCounts();
    trig_cnt = 0; upd_cnt = 0; done_cnt = 0; bad_cnt = 0; to_cnt = 0;
    trig_cyc = -1; first_upd_cyc = -1; done_cyc = -1; bad_cyc = -1; to_cyc = -1; fall_cyc = -1;
    snap_data = '0; snap_bits = '0; snap_fb = 1'b0; first_data = '0; first_bits = '0;
  endtask

  task automatic applyStimulus(input logic [4:0] a, input logic [31:0] d, input logic [3:0] ch,
                               input logic upd, input logic fb);
    int k;
    clearCounts();
    req_addr      = a;
    req_data      = d;
    req_chan      = ch;
    req_update    = upd;
    four_bit_mode = fb;
    k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) checkOutput("ready_wait", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    tick();
    accept_cyc = cyc;
    req_valid  = 1'b0;
  endtask

  task automatic serve(input int budget, input bit stop_on_upd);
    bit finished;
    finished = 1'b0;
    for (int k = 0; k < budget && !finished; k++) begin
      if (done_cnt > 0 || bad_cnt > 0 || to_cnt > 0) finished = 1'b1;
      else if (stop_on_upd && upd_cnt > 0) finished = 1'b1;
      else tick();
    end
    if (!finished && !(done_cnt > 0 || bad_cnt > 0 || to_cnt > 0 || (stop_on_upd && upd_cnt > 0)))
      checkOutput("serve_budget", 64'd0, 64'd1);
    if (!stop_on_upd) begin
      for (int k = 0; k < 3; k++) tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not terminate");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int release_cyc;
    vecs[0]  = '{5'h04, 32'h12345678, 1'b1, 1'b0, 1'b0, 6'd40, 64'h04_1234_5678};
    vecs[1]  = '{5'h05, 32'hFFFF3FFF, 1'b0, 1'b0, 1'b0, 6'd24, 64'h05_3FFF};
    vecs[2]  = '{5'h00, 32'h1234562C, 1'b0, 1'b1, 1'b0, 6'd16, 64'h00_2C};
    vecs[3]  = '{5'h01, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 6'd32, 64'h01_BBCCDD};
    vecs[4]  = '{5'h02, 32'h0000BEEF, 1'b0, 1'b1, 1'b0, 6'd24, 64'h02_BEEF};
    vecs[5]  = '{5'h03, 32'h00FF00FF, 1'b0, 1'b0, 1'b0, 6'd32, 64'h03_FF00FF};
    vecs[6]  = '{5'h07, 32'h11112222, 1'b0, 1'b0, 1'b0, 6'd24, 64'h07_2222};
    vecs[7]  = '{5'h18, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 6'd40, 64'h18_DEADBEEF};
    vecs[8]  = '{5'h19, 32'h00000000, 1'b0, 1'b0, 1'b1, 6'd0,  64'h0};
    vecs[9]  = '{5'h1F, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 6'd0,  64'h0};
    vecs[10] = '{5'h06, 32'h87654321, 1'b0, 1'b0, 1'b0, 6'd32, 64'h06_654321};
    vecs[11] = '{5'h0A, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0, 6'd40, 64'h0A_CAFEF00D};

    clearCounts();
    for (int k = 0; k < 3; k++) tick();
    checkOutput("rst_req_ready", {63'b0, req_ready}, 64'd1);
    checkOutput("rst_trigger", {63'b0, spi_trigger}, 64'd0);
    checkOutput("rst_io_update", {63'b0, io_update}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    checkOutput("rst_errs", {62'b0, err_bad_addr, err_timeout}, 64'd0);
    checkOutput("rst_spi_data", spi_data, 64'd0);
    checkOutput("rst_bits", {58'b0, spi_bits_to_send}, 64'd0);
    checkOutput("rst_four_bit", {63'b0, spi_four_bit}, 64'd0);
    reset = 1'b0;
    tick();

    $display("[TB] reset held during io_update");
    applyStimulus(5'h04, 32'h12345678, 4'h2, 1'b1, 1'b0);
    serve(100, 1'b1);
    checkOutput("midupd_seen", {63'b0, io_update}, 64'd1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("midupd_io_update", {63'b0, io_update}, 64'd0);
      checkOutput("midupd_req_ready", {63'b0, req_ready}, 64'd1);
      checkOutput("midupd_trigger", {63'b0, spi_trigger}, 64'd0);
    end
    reset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) tick();
    checkOutput("midupd_no_done", 64'(done_cnt), 64'd0);
    checkOutput("midupd_spi_data", spi_data, 64'd0);

    $display("[TB] channel shadow sequence");
    applyStimulus(5'h04, 32'h12345678, 4'h2, 1'b0, 1'b0);
    serve(100, 1'b0);
`ifdef AD9958_CSR_SHADOW_EN
    checkOutput("shadow1_trig_cnt", 64'(trig_cnt), 64'd2);
    checkOutput("shadow1_csr_data", first_data, 64'h00_20);
    checkOutput("shadow1_csr_bits", {58'b0, first_bits}, 64'd16);
`else
    checkOutput("shadow1_trig_cnt", 64'(trig_cnt), 64'd1);
`endif
    checkOutput("shadow1_data", snap_data, 64'h04_1234_5678);
    checkOutput("shadow1_done", 64'(done_cnt), 64'd1);
    applyStimulus(5'h05, 32'hFFFF3FFF, 4'h2, 1'b0, 1'b0);
    serve(100, 1'b0);
    checkOutput("shadow2_trig_cnt", 64'(trig_cnt), 64'd1);
    checkOutput("shadow2_data", snap_data, 64'h05_3FFF);

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].addr, vecs[i].data, 4'h2, vecs[i].upd, vecs[i].fb);
      serve(100, 1'b0);
      if (vecs[i].bad) begin
        checkOutput($sformatf("v%0d_bad_cnt", i), 64'(bad_cnt), 64'd1);
        checkOutput($sformatf("v%0d_bad_cyc", i), 64'(bad_cyc), 64'(accept_cyc));
        checkOutput($sformatf("v%0d_no_trig", i), 64'(trig_cnt), 64'd0);
        checkOutput($sformatf("v%0d_no_done", i), 64'(done_cnt), 64'd0);
        checkOutput($sformatf("v%0d_ready", i), {63'b0, req_ready}, 64'd1);
      end else begin
        checkOutput($sformatf("v%0d_trig_cnt", i), 64'(trig_cnt), 64'd1);
        checkOutput($sformatf("v%0d_latency", i), 64'(trig_cyc - accept_cyc), 64'd2);
        checkOutput($sformatf("v%0d_bits", i), {58'b0, snap_bits}, {58'b0, vecs[i].exp_bits});
        checkOutput($sformatf("v%0d_data", i), snap_data, vecs[i].exp_data);
        checkOutput($sformatf("v%0d_four_bit", i), {63'b0, snap_fb}, {63'b0, vecs[i].fb});
        checkOutput($sformatf("v%0d_done_cnt", i), 64'(done_cnt), 64'd1);
        checkOutput($sformatf("v%0d_upd_cnt", i), 64'(upd_cnt), vecs[i].upd ? 64'd4 : 64'd0);
        checkOutput($sformatf("v%0d_done_cyc", i), 64'(done_cyc - fall_cyc), vecs[i].upd ? 64'd5 : 64'd1);
        if (vecs[i].upd)
          checkOutput($sformatf("v%0d_upd_start", i), 64'(first_upd_cyc - fall_cyc), 64'd1);
        checkOutput($sformatf("v%0d_no_err", i), 64'(bad_cnt + to_cnt), 64'd0);
      end
    end

    $display("[TB] stale busy before trigger");
    spi_busy = 1'b1;
    applyStimulus(5'h08, 32'h00000001, 4'h2, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) tick();
    checkOutput("stale_no_trig", 64'(trig_cnt), 64'd0);
    spi_busy = 1'b0;
    release_cyc = cyc;
    serve(100, 1'b0);
    checkOutput("stale_trig_cyc", 64'(trig_cyc - release_cyc), 64'd1);
    checkOutput("stale_data", snap_data, 64'h08_0000_0001);
    checkOutput("stale_no_timeout", 64'(to_cnt), 64'd0);
    checkOutput("stale_done", 64'(done_cnt), 64'd1);

    $display("[TB] ack timeout");
    no_busy = 1'b1;
    applyStimulus(5'h09, 32'h55AA55AA, 4'h2, 1'b1, 1'b0);
    serve(200, 1'b0);
    checkOutput("to_cnt", 64'(to_cnt), 64'd1);
    checkOutput("to_delay", 64'(to_cyc - trig_cyc), 64'd64);
    checkOutput("to_no_done", 64'(done_cnt), 64'd0);
    checkOutput("to_no_update", 64'(upd_cnt), 64'd0);
    checkOutput("to_ready", {63'b0, req_ready}, 64'd1);
    no_busy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
